// File: rtl/float_alu_arbiter.sv
// Round-robin arbiter sharing one float_alu between N_REQ requesters.
// One operation is in flight at a time: accept -> issue start -> wait for
// valid (with watchdog) -> hold the response until its owner takes it.
module float_alu_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_op_a,
  input  logic [32*N_REQ-1:0]  req_op_b,
  input  logic [3*N_REQ-1:0]   req_op_code,
  input  logic [N_REQ-1:0]     req_round_mode,
  input  logic [N_REQ-1:0]     req_mode_fp,
  output logic [N_REQ-1:0]     resp_valid,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic [31:0]          resp_result,
  output logic [4:0]           resp_flags,
  output logic                 resp_timeout,
  output logic [31:0]          alu_op_a,
  output logic [31:0]          alu_op_b,
  output logic [2:0]           alu_op_code,
  output logic                 alu_round_mode,
  output logic                 alu_mode_fp,
  output logic                 alu_start,
  output logic                 alu_ready_in,
  input  logic                 alu_ready_out,
  input  logic                 alu_valid_out,
  input  logic [31:0]          alu_result,
  input  logic [4:0]           alu_flags
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_r;
  state_t            state_s;
  logic [GW-1:0]     g_r;
  logic [GW-1:0]     last_r;
  logic [CW-1:0]     cnt_r;
  logic [GW-1:0]     winner_s;
  logic              found_s;
  logic              expire_s;
  logic [N_REQ-1:0]  grant_onehot_s;

  // Rotating-priority scan starting just after the last served requester.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found_s && req_valid[(int'(last_r) + k) % N_REQ]) begin
        found_s  = 1'b1;
        winner_s = GW'((int'(last_r) + k) % N_REQ);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Acceptance strobe and start pulse depend on same-cycle inputs.
  always_comb begin
    req_ready = '0;
    if (state_r == IDLE && found_s) begin
      req_ready[winner_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
    alu_start = (state_r == ISSUE) && alu_ready_out;
  end

  // One-hot decode of the owner of the in-flight operation.
  always_comb begin
    grant_onehot_s      = '0;
    grant_onehot_s[g_r] = 1'b1;
  end

  assign expire_s = (cnt_r == CW'(TIMEOUT_CYCLES - 1));

  // Next-state logic for the accept/issue/wait/respond sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) state_s = ISSUE;
        else         state_s = IDLE;
      end
      ISSUE: begin
        if (alu_ready_out) state_s = WAIT;
        else               state_s = ISSUE;
      end
      WAIT: begin
        if (alu_valid_out || expire_s) state_s = RESP;
        else                           state_s = WAIT;
      end
      RESP: begin
        if (resp_ready[g_r]) state_s = IDLE;
        else                 state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, operand latches, watchdog counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      g_r            <= '0;
      last_r         <= GW'(N_REQ - 1);
      cnt_r          <= '0;
      alu_op_a       <= 32'd0;
      alu_op_b       <= 32'd0;
      alu_op_code    <= 3'd0;
      alu_round_mode <= 1'b0;
      alu_mode_fp    <= 1'b0;
      alu_ready_in   <= 1'b0;
      resp_valid     <= '0;
      resp_result    <= 32'd0;
      resp_flags     <= 5'd0;
      resp_timeout   <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            g_r            <= winner_s;
            alu_op_a       <= req_op_a[int'(winner_s)*32 +: 32];
            alu_op_b       <= req_op_b[int'(winner_s)*32 +: 32];
            alu_op_code    <= req_op_code[int'(winner_s)*3 +: 3];
            alu_round_mode <= req_round_mode[winner_s];
            alu_mode_fp    <= req_mode_fp[winner_s];
          end else begin
            g_r <= g_r;
          end
          cnt_r <= '0;
        end
        WAIT: begin
          if (alu_valid_out) begin
            resp_result  <= alu_result;
            resp_flags   <= alu_flags;
            resp_timeout <= 1'b0;
            cnt_r        <= '0;
          end else if (expire_s) begin
            resp_result  <= 32'd0;
            resp_flags   <= 5'b00000;
            resp_timeout <= 1'b1;
            cnt_r        <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        RESP: begin
          if (resp_ready[g_r]) last_r <= g_r;
          else                 last_r <= last_r;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
      alu_ready_in <= (state_s == WAIT);
      resp_valid   <= (state_s == RESP) ? grant_onehot_s : '0;
    end
  end

endmodule
